// File: rtl/ctrl_pkt_pkg.sv
// ctrl_pkt_pkg: shared constants, header template and FSM states for the control packet generator
package ctrl_pkt_pkg;
  localparam int HDR_BYTES = 42;
  localparam int DPORT_OFS = 36;
  localparam int STAGE_OFS = 42;
  localparam int MOD_OFS = 43;
  localparam int ADDR_OFS = 44;
  localparam int PAY0_OFS = 45;
  localparam logic [15:0] PKT_LEN = 16'd124;
  localparam logic [63:0] BEAT1_KEEP = 64'h0FFF_FFFF_FFFF_FFFF;
  // byte 0 sits in the MSBs; the UDP destination port bytes are overwritten from the parameter
  localparam logic [HDR_BYTES*8-1:0] HDR_TMPL = {
    48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h0800,
    32'h45_00_00_6E, 32'h00_00_40_00, 32'h40_11_00_00, 32'hC0_A8_00_01, 32'hC0_A8_00_02,
    32'h12_34_F1_F2, 32'h00_5A_00_00
  };
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;
endpackage

// File: rtl/ctrl_pkt_fmt.sv
// ctrl_pkt_fmt: maps one table-write request onto the two control-bus beats
module ctrl_pkt_fmt
  import ctrl_pkt_pkg::*;
#(
  parameter int ACT_LEN = 25,
  parameter logic [15:0] CTRL_UDP_PORT = 16'hF1F2
) (
  input  logic [4:0]             stage_id,
  input  logic [7:0]             module_id,
  input  logic [7:0]             addr,
  input  logic [ACT_LEN*25-1:0]  data,
  output logic [511:0]           beat0,
  output logic [511:0]           beat1
);
  localparam int PW = ACT_LEN*25+7;
  logic [PW-1:0] pay;
  assign pay = {data, 7'b0};
  always_comb begin
    beat0 = '0;
    beat1 = '0;
    for (int k = 0; k < HDR_BYTES; k++) beat0[8*k +: 8] = HDR_TMPL[HDR_BYTES*8-1-8*k -: 8];
    beat0[8*DPORT_OFS +: 16] = {CTRL_UDP_PORT[7:0], CTRL_UDP_PORT[15:8]};
    beat0[8*STAGE_OFS +: 8] = {stage_id, 3'b000};
    beat0[8*MOD_OFS +: 8] = module_id;
    beat0[8*ADDR_OFS +: 8] = addr;
    for (int j = 0; j < 19; j++) beat0[8*(PAY0_OFS+j) +: 8] = pay[PW-1-8*j -: 8];
    for (int i = 0; i < 60; i++) beat1[8*i +: 8] = pay[PW-1-8*(19+i) -: 8];
  end
endmodule

// File: rtl/ctrl_pkt_gen.sv
// ctrl_pkt_gen: serializes table-write requests into 2-beat AXI-Stream control packets
module ctrl_pkt_gen
  import ctrl_pkt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int ACT_LEN = 25,
  parameter logic [15:0] CTRL_UDP_PORT = 16'hF1F2,
  parameter logic [7:0] SRC_PORT = 8'h01
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_req_valid,
  output logic                              wr_req_ready,
  input  logic [4:0]                        wr_stage_id,
  input  logic [7:0]                        wr_module_id,
  input  logic [7:0]                        wr_addr,
  input  logic [ACT_LEN*25-1:0]             wr_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  input  logic                              c_m_axis_tready,
  output logic [31:0]                       pkt_cnt
);
  localparam logic [C_S_AXIS_TUSER_WIDTH-1:0] TUSER = {{(C_S_AXIS_TUSER_WIDTH-24){1'b0}}, SRC_PORT, PKT_LEN};
  state_e state_q, state_d;
  logic [4:0] stage_q, stage_d;
  logic [7:0] mod_q, mod_d, addr_q, addr_d;
  logic [ACT_LEN*25-1:0] data_q, data_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] tkeep_q, tkeep_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [31:0] cnt_q, cnt_d;
  logic accept, load1, done, drop;
  logic [511:0] beat0, beat1;
  assign wr_req_ready = !rst && (state_q == IDLE || (state_q == PAY && c_m_axis_tready));
  // the formatter sees the incoming request on accept so beat 0 is registered without a bubble
  ctrl_pkt_fmt #(.ACT_LEN(ACT_LEN), .CTRL_UDP_PORT(CTRL_UDP_PORT)) u_fmt (
    .stage_id(stage_d), .module_id(mod_d), .addr(addr_d), .data(data_d),
    .beat0(beat0), .beat1(beat1)
  );
  always_comb begin
    accept = wr_req_valid && wr_req_ready;
    load1 = state_q == HDR && c_m_axis_tready;
    done = state_q == PAY && c_m_axis_tready;
    drop = done && !accept;
    state_d = accept ? HDR : load1 ? PAY : drop ? IDLE : state_q;
    stage_d = accept ? wr_stage_id : stage_q;
    mod_d = accept ? wr_module_id : mod_q;
    addr_d = accept ? wr_addr : addr_q;
    data_d = accept ? wr_data : data_q;
    tdata_d = accept ? beat0 : load1 ? beat1 : drop ? '0 : tdata_q;
    tuser_d = (accept || load1) ? TUSER : drop ? '0 : tuser_q;
    tkeep_d = accept ? '1 : load1 ? BEAT1_KEEP : drop ? '0 : tkeep_q;
    tvalid_d = accept || load1 || (tvalid_q && !drop);
    tlast_d = load1 || (tlast_q && !accept && !drop);
    cnt_d = cnt_q + 32'(done);
  end
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
    mod_q <= mod_d;
    addr_q <= addr_d;
    data_q <= data_d;
    if (rst) begin
      state_q <= IDLE;
      tdata_q <= '0;
      tuser_q <= '0;
      tkeep_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
      tkeep_q <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      cnt_q <= cnt_d;
    end
  end
  assign c_m_axis_tdata = tdata_q;
  assign c_m_axis_tuser = tuser_q;
  assign c_m_axis_tkeep = tkeep_q;
  assign c_m_axis_tvalid = tvalid_q;
  assign c_m_axis_tlast = tlast_q;
  assign pkt_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// tb_ctrl_pkt_gen: randomized bench comparing ctrl_pkt_gen against a byte-level packet model
module tb_ctrl_pkt_gen;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic wr_req_valid = 0, wr_req_ready, c_m_axis_tready = 0;
  logic [4:0] wr_stage_id = 0;
  logic [7:0] wr_module_id = 0, wr_addr = 0;
  logic [624:0] wr_data = '0;
  logic [511:0] c_m_axis_tdata;
  logic [127:0] c_m_axis_tuser;
  logic [63:0] c_m_axis_tkeep;
  logic c_m_axis_tvalid, c_m_axis_tlast;
  logic [31:0] pkt_cnt;
  ctrl_pkt_gen dut (
    .clk(clk), .rst(rst), .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_stage_id(wr_stage_id), .wr_module_id(wr_module_id), .wr_addr(wr_addr), .wr_data(wr_data),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser), .c_m_axis_tkeep(c_m_axis_tkeep),
    .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tlast(c_m_axis_tlast),
    .c_m_axis_tready(c_m_axis_tready), .pkt_cnt(pkt_cnt)
  );
  typedef struct {logic [511:0] d; logic [127:0] u; logic [63:0] k; logic l;} beat_t;
  beat_t exp_q[$];
  logic [31:0] exp_cnt = 0;
  int checks = 0, failures = 0, accepts = 0;
  logic [4:0] cur_stage;
  logic [7:0] cur_mod, cur_addr;
  logic [624:0] cur_data;
  logic stalled = 0;
  logic [704:0] snap;
  logic [7:0] hdr [42] = '{
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h08, 8'h00,
    8'h45, 8'h00, 8'h00, 8'h6E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
    8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02,
    8'h12, 8'h34, 8'hF1, 8'hF2, 8'h00, 8'h5A, 8'h00, 8'h00};

  task automatic check(input string tag, input logic [704:0] got, input logic [704:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // whole packet as a 124-byte array, then cut into 64-byte beats
  task automatic push_pkt(input logic [4:0] s, input logic [7:0] m, input logic [7:0] a, input logic [624:0] d);
    logic [7:0] pkt [124];
    logic [631:0] p;
    beat_t b0, b1;
    p = {d, 7'b0};
    for (int i = 0; i < 42; i++) pkt[i] = hdr[i];
    pkt[42] = {s, 3'b0};
    pkt[43] = m;
    pkt[44] = a;
    for (int j = 0; j < 79; j++) pkt[45+j] = p[631-8*j -: 8];
    b0.d = '0; b1.d = '0; b1.k = '0;
    for (int i = 0; i < 64; i++) b0.d[8*i +: 8] = pkt[i];
    for (int i = 0; i < 60; i++) begin
      b1.d[8*i +: 8] = pkt[64+i];
      b1.k[i] = 1'b1;
    end
    b0.u = {104'b0, 8'h01, 16'd124};
    b1.u = b0.u;
    b0.k = '1;
    b0.l = 0;
    b1.l = 1;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
  endtask

  task automatic cycle(input bit v, input bit rdy, input bit r);
    logic exp_rdy;
    @(negedge clk);
    wr_req_valid = v; c_m_axis_tready = rdy; rst = r;
    wr_stage_id = cur_stage; wr_module_id = cur_mod; wr_addr = cur_addr; wr_data = cur_data;
    #1;
    exp_rdy = !r && (exp_q.size() == 0 || (rdy && exp_q.size() == 1));
    check("ready", 705'(wr_req_ready), 705'(exp_rdy));
    check("tvalid", 705'(c_m_axis_tvalid), 705'(exp_q.size() != 0));
    check("pkt_cnt", 705'(pkt_cnt), 705'(exp_cnt));
    if (!c_m_axis_tvalid) check("idle_zero", {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep}, '0);
    if (stalled) check("hold", {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast}, snap);
    stalled = c_m_axis_tvalid && !rdy && !r;
    snap = {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast};
    if (r) begin
      exp_q.delete();
      exp_cnt = 0;
      stalled = 0;
    end else begin
      if (c_m_axis_tvalid && rdy && exp_q.size() != 0) begin
        check("tdata", 705'(c_m_axis_tdata), 705'(exp_q[0].d));
        check("tuser", 705'(c_m_axis_tuser), 705'(exp_q[0].u));
        check("tkeep", 705'(c_m_axis_tkeep), 705'(exp_q[0].k));
        check("tlast", 705'(c_m_axis_tlast), 705'(exp_q[0].l));
        if (exp_q[0].l) exp_cnt++;
        void'(exp_q.pop_front());
      end
      if (v && wr_req_ready) begin
        push_pkt(cur_stage, cur_mod, cur_addr, cur_data);
        accepts++;
      end
    end
  endtask

  task automatic rand_req();
    cur_stage = 5'($urandom);
    cur_mod = 8'($urandom);
    cur_addr = 8'($urandom);
    cur_data = '0;
    for (int i = 0; i < 20; i++) cur_data = (cur_data << 32) | 625'($urandom);
    if ($urandom_range(7) == 0) cur_data = '1;
    if ($urandom_range(7) == 0) cur_data = '0;
  endtask

  initial begin
    rand_req();
    cycle(0, 0, 1); cycle(0, 0, 1); cycle(0, 1, 0);
    // single write
    cur_stage = 3; cur_mod = 1; cur_addr = 8'h05; cur_data = 625'h1;
    cycle(1, 1, 0);
    @(posedge clk); #1;
    check("s_b42", 705'(c_m_axis_tdata[343:336]), 705'(8'h18));
    check("s_b43", 705'(c_m_axis_tdata[351:344]), 705'(8'h01));
    check("s_b44", 705'(c_m_axis_tdata[359:352]), 705'(8'h05));
    cycle(0, 1, 0);
    @(posedge clk); #1;
    check("s_b59", 705'(c_m_axis_tdata[479:472]), 705'(8'h80));
    check("s_keep", 705'(c_m_axis_tkeep), 705'(64'h0FFF_FFFF_FFFF_FFFF));
    check("s_last", 705'(c_m_axis_tlast), 705'(1'b1));
    cycle(0, 1, 0); cycle(0, 1, 0);
    check("s_cnt", 705'(pkt_cnt), 705'(32'd1));
    // backpressure on both beats
    rand_req();
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    cycle(0, 1, 0); cycle(0, 1, 0);
    // back-to-back
    accepts = 0;
    for (int i = 0; i < 9; i++) begin
      rand_req();
      cycle(accepts < 4, 1, 0);
    end
    cycle(0, 1, 0);
    check("b2b_cnt", 705'(pkt_cnt), 705'(32'd6));
    // reset after beat 0 accepted
    rand_req();
    cycle(1, 1, 0); cycle(0, 1, 0); cycle(0, 1, 1); cycle(0, 1, 0);
    check("rst_cnt", 705'(pkt_cnt), 705'(32'd0));
    rand_req();
    cycle(1, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
    // field boundaries
    cur_stage = 5'd31; cur_mod = 8'hFF; cur_addr = 8'hFF; cur_data = '1;
    cycle(1, 1, 0);
    @(posedge clk); #1;
    check("bd_b42", 705'(c_m_axis_tdata[343:336]), 705'(8'hF8));
    check("bd_tuser", 705'(c_m_axis_tuser[23:0]), 705'(24'h01_007C));
    cycle(0, 1, 0);
    @(posedge clk); #1;
    check("bd_b59", 705'(c_m_axis_tdata[479:472]), 705'(8'h80));
    check("bd_b58", 705'(c_m_axis_tdata[471:464]), 705'(8'hFF));
    cycle(0, 1, 0); cycle(0, 1, 0);
    // counter wrap
    exp_cnt = '1;
    force dut.cnt_q = '1;
    cycle(0, 1, 0); cycle(0, 1, 0);
    release dut.cnt_q;
    cycle(0, 1, 0);
    rand_req();
    cycle(1, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);
    check("wrap_cnt", 705'(pkt_cnt), 705'(32'd0));
    // random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rand_req();
      cycle($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(299) == 0);
    end
    for (int n = 0; n < 4; n++) cycle(0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
